// File: rtl/regf_sb_pkg.sv
// Shared register-file helpers: derived address/count widths, default sizes and flat-bus slicing.
// Imported by the register file, its scoreboard and the bus interface.
`ifndef REGF_SLICE
`define REGF_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package regf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int aw_of(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  // Counter width must hold NREGS itself, hence the +1.
  function automatic int cw_of(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regf_sb_if.sv
// Read, write-back and issue signals of the register file, grouped as one bus.
interface regf_sb_if
  import regf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = aw_of(NREGS);
  localparam int CW = cw_of(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic [CW-1:0]       nbusy;

  modport master (
    output raddr, we, waddr, wdata, iss_valid, iss_rd,
    input  rdata, rbusy, iss_ready, nbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_valid, iss_rd,
    output rdata, rbusy, iss_ready, nbusy
  );
endinterface

// File: rtl/regf_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears (set wins), registered busy count.
// iss_ready depends only on registered busy state, so a same-cycle write-back never unblocks it.
module regf_scoreboard
  import regf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NWR   = 1,
  localparam int AW    = aw_of(NREGS),
  localparam int CW    = cw_of(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  output logic [NREGS-1:0]  busy,
  output logic [CW-1:0]     nbusy
);

  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             iss_fire;

  assign iss_ready = rst_n & ~busy[iss_rd];
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (`REGF_SLICE(waddr, j, AW) != '0))
        busy_nxt[`REGF_SLICE(waddr, j, AW)] = 1'b0;
    end
    // Applied after the clears: a new producer supersedes the one writing back.
    if (iss_fire && (iss_rd != '0))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      nbusy <= '0;
    end else begin
      busy  <= busy_nxt;
      nbusy <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regf_sb.sv
// Multi-port register file with x0 hard-wired to zero, optional write-to-read bypass and scoreboard.
// Reads are combinational; writes and busy updates land on the rising edge.
module regf_sb
  import regf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input logic      clk,
  input logic      rst_n,
  regf_sb_if.slave bus
);

  localparam int AW = aw_of(NREGS);

  logic [XLEN-1:0]  mem  [NREGS];
  logic [XLEN-1:0]  wval [NREGS];
  logic [NREGS-1:0] wen;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0]  rd_dat [NRD];
  logic [NRD-1:0]   rd_busy;

  regf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_ready (bus.iss_ready),
    .we        (bus.we),
    .waddr     (bus.waddr),
    .busy      (busy),
    .nbusy     (bus.nbusy)
  );

  // Ascending port order lets the highest-index writer win a conflict.
  always_comb begin
    wen = '0;
    for (int r = 0; r < NREGS; r++)
      wval[r] = '0;
    for (int j = 0; j < NWR; j++) begin
      if (bus.we[j] && (`REGF_SLICE(bus.waddr, j, AW) != '0)) begin
        wen[`REGF_SLICE(bus.waddr, j, AW)]  = 1'b1;
        wval[`REGF_SLICE(bus.waddr, j, AW)] = `REGF_SLICE(bus.wdata, j, XLEN);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (wen[r])
          mem[r] <= wval[r];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = `REGF_SLICE(bus.raddr, k, AW);

    always_comb begin
      rd_dat[k]  = mem[ra];
      rd_busy[k] = busy[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.we[j] && (`REGF_SLICE(bus.waddr, j, AW) != '0) &&
              (`REGF_SLICE(bus.waddr, j, AW) == ra)) begin
            rd_dat[k]  = `REGF_SLICE(bus.wdata, j, XLEN);
            rd_busy[k] = 1'b0;
          end
        end
      end
      if ((ra == '0) || !rst_n) begin
        rd_dat[k]  = '0;
        rd_busy[k] = 1'b0;
      end
    end

    assign `REGF_SLICE(bus.rdata, k, XLEN) = rd_dat[k];
    assign bus.rbusy[k] = rd_busy[k];
  end

endmodule

// File: tb/tb_regf_sb.sv
// Directed bench: a bypassing 2-write-port instance (da) and a non-bypassing 1-write-port instance (db).
module tb_regf_sb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regf_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) a ();
  regf_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) b ();

  regf_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) da (
    .clk (clk), .rst_n (rst_n), .bus (a)
  );

  regf_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) db (
    .clk (clk), .rst_n (rst_n), .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    a.we = '0; a.waddr = '0; a.wdata = '0; a.iss_valid = 1'b0; a.iss_rd = '0;
    b.we = '0; b.waddr = '0; b.wdata = '0; b.iss_valid = 1'b0; b.iss_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    a.raddr = {5'd0, 5'd5};
    b.raddr = '0;
    #1;
    checks++; if (a.rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", a.rdata); end
    checks++; if (a.rbusy !== 2'b00) begin errors++; $display("FAIL rst_rbusy got %b want 00", a.rbusy); end
    checks++; if (a.iss_ready !== 1'b0) begin errors++; $display("FAIL rst_iss_ready got %b want 0", a.iss_ready); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL rst_nbusy got %0d want 0", a.nbusy); end
    step();
    rst_n = 1'b1;
    a.we = 2'b01; a.waddr = {5'd0, 5'd5}; a.wdata = {32'd0, 32'hDEADBEEF};
    a.iss_valid = 1'b1; a.iss_rd = 5'd6;
    step();
    idle();
    #1;
    checks++; if (a.rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_written got %h want deadbeef", a.rdata[31:0]); end
    checks++; if (a.nbusy !== 6'd1) begin errors++; $display("FAIL pre_rst_nbusy got %0d want 1", a.nbusy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a.rdata[31:0] !== 32'd0) begin errors++; $display("FAIL rst_pulse_rdata got %h want 0", a.rdata[31:0]); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL rst_pulse_nbusy got %0d want 0", a.nbusy); end
    #1 rst_n = 1'b1;
    step();
    checks++; if (a.rdata[31:0] !== 32'd0) begin errors++; $display("FAIL x5_cleared got %h want 0", a.rdata[31:0]); end
  endtask

  task automatic test_x0();
    a.we = 2'b01; a.waddr = {5'd0, 5'd0}; a.wdata = {32'd0, 32'hFFFFFFFF};
    a.iss_valid = 1'b1; a.iss_rd = 5'd0;
    a.raddr = {5'd0, 5'd0};
    #1;
    checks++; if (a.iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %b want 1", a.iss_ready); end
    checks++; if (a.rdata[31:0] !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h want 0", a.rdata[31:0]); end
    step();
    idle();
    #1;
    checks++; if (a.rdata[31:0] !== 32'd0) begin errors++; $display("FAIL x0_read got %h want 0", a.rdata[31:0]); end
    checks++; if (a.rbusy[0] !== 1'b0) begin errors++; $display("FAIL x0_rbusy got %b want 0", a.rbusy[0]); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL x0_nbusy got %0d want 0", a.nbusy); end
  endtask

  task automatic test_bypass();
    a.iss_valid = 1'b1; a.iss_rd = 5'd3;
    b.iss_valid = 1'b1; b.iss_rd = 5'd3;
    a.raddr = {5'd0, 5'd3};
    b.raddr = {5'd0, 5'd3};
    step();
    idle();
    #1;
    checks++; if (a.rbusy[0] !== 1'b1) begin errors++; $display("FAIL byp_busy_a got %b want 1", a.rbusy[0]); end
    checks++; if (b.nbusy !== 6'd1) begin errors++; $display("FAIL byp_nbusy_b got %0d want 1", b.nbusy); end
    a.we = 2'b01; a.waddr = {5'd0, 5'd3}; a.wdata = {32'd0, 32'h1234};
    b.we = 1'b1;  b.waddr = 5'd3;         b.wdata = 32'h1234;
    #1;
    checks++; if (a.rdata[31:0] !== 32'h1234) begin errors++; $display("FAIL byp_on_rdata got %h want 1234", a.rdata[31:0]); end
    checks++; if (a.rbusy[0] !== 1'b0) begin errors++; $display("FAIL byp_on_rbusy got %b want 0", a.rbusy[0]); end
    checks++; if (b.rdata[31:0] !== 32'd0) begin errors++; $display("FAIL byp_off_rdata got %h want 0", b.rdata[31:0]); end
    checks++; if (b.rbusy[0] !== 1'b1) begin errors++; $display("FAIL byp_off_rbusy got %b want 1", b.rbusy[0]); end
    step();
    idle();
    #1;
    checks++; if (b.rdata[31:0] !== 32'h1234) begin errors++; $display("FAIL byp_off_next got %h want 1234", b.rdata[31:0]); end
    checks++; if (b.rbusy[0] !== 1'b0) begin errors++; $display("FAIL byp_off_next_busy got %b want 0", b.rbusy[0]); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL byp_nbusy_a got %0d want 0", a.nbusy); end
  endtask

  task automatic test_conflict();
    a.we = 2'b11; a.waddr = {5'd7, 5'd7}; a.wdata = {32'hBB, 32'hAA};
    a.raddr = {5'd7, 5'd0};
    #1;
    checks++; if (a.rdata[63:32] !== 32'hBB) begin errors++; $display("FAIL conf_bypass got %h want bb", a.rdata[63:32]); end
    step();
    idle();
    #1;
    checks++; if (a.rdata[63:32] !== 32'hBB) begin errors++; $display("FAIL conf_stored got %h want bb", a.rdata[63:32]); end
  endtask

  task automatic test_scoreboard();
    a.raddr = {5'd0, 5'd4};
    a.iss_valid = 1'b1; a.iss_rd = 5'd4;
    #1;
    checks++; if (a.iss_ready !== 1'b1) begin errors++; $display("FAIL sb_ready_free got %b want 1", a.iss_ready); end
    step();
    a.iss_valid = 1'b0;
    #1;
    checks++; if (a.nbusy !== 6'd1) begin errors++; $display("FAIL sb_nbusy_set got %0d want 1", a.nbusy); end
    checks++; if (a.iss_ready !== 1'b0) begin errors++; $display("FAIL sb_ready_busy got %b want 0", a.iss_ready); end
    checks++; if (a.rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_rbusy got %b want 1", a.rbusy[0]); end
    a.we = 2'b10; a.waddr = {5'd4, 5'd0}; a.wdata = {32'h44, 32'd0};
    step();
    idle();
    a.iss_rd = 5'd4;
    #1;
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL sb_nbusy_clr got %0d want 0", a.nbusy); end
    checks++; if (a.iss_ready !== 1'b1) begin errors++; $display("FAIL sb_ready_clr got %b want 1", a.iss_ready); end
    a.iss_valid = 1'b1;
    a.we = 2'b01; a.waddr = {5'd0, 5'd4}; a.wdata = {32'd0, 32'h55};
    step();
    idle();
    #1;
    checks++; if (a.rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", a.rbusy[0]); end
    checks++; if (a.nbusy !== 6'd1) begin errors++; $display("FAIL sb_set_wins_n got %0d want 1", a.nbusy); end
    checks++; if (a.rdata[31:0] !== 32'h55) begin errors++; $display("FAIL sb_set_wins_dat got %h want 55", a.rdata[31:0]); end
    a.we = 2'b01; a.waddr = {5'd0, 5'd4}; a.wdata = {32'd0, 32'h66};
    step();
    idle();
  endtask

  task automatic test_stall();
    a.iss_valid = 1'b1; a.iss_rd = 5'd9;
    step();
    #1;
    checks++; if (a.iss_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", a.iss_ready); end
    step();
    checks++; if (a.nbusy !== 6'd1) begin errors++; $display("FAIL stall_nbusy got %0d want 1", a.nbusy); end
    a.we = 2'b01; a.waddr = {5'd0, 5'd9}; a.wdata = {32'd0, 32'h99};
    #1;
    checks++; if (a.iss_ready !== 1'b0) begin errors++; $display("FAIL stall_wb_same got %b want 0", a.iss_ready); end
    step();
    a.we = '0;
    #1;
    checks++; if (a.iss_ready !== 1'b1) begin errors++; $display("FAIL stall_unblock got %b want 1", a.iss_ready); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL stall_nbusy_clr got %0d want 0", a.nbusy); end
    step();
    idle();
    checks++; if (a.nbusy !== 6'd1) begin errors++; $display("FAIL stall_reissue got %0d want 1", a.nbusy); end
  endtask

  task automatic test_reset_midop();
    a.we = 2'b01; a.waddr = {5'd0, 5'd10}; a.wdata = {32'd0, 32'hA5A5};
    a.iss_valid = 1'b1; a.iss_rd = 5'd11;
    a.raddr = {5'd11, 5'd10};
    rst_n = 1'b0;
    step();
    idle();
    rst_n = 1'b1;
    #1;
    checks++; if (a.rdata !== 64'd0) begin errors++; $display("FAIL midrst_rdata got %h want 0", a.rdata); end
    checks++; if (a.nbusy !== 6'd0) begin errors++; $display("FAIL midrst_nbusy got %0d want 0", a.nbusy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_x0();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_stall();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
